// File: rtl/multicycle_ctrl_if.sv
// rtl/multicycle_ctrl_if.sv - datapath-facing control bundle for the multi-cycle sequencer
// master = sequencer side, slave = datapath/core side
interface multicycle_ctrl_if;
  logic [31:0] i_instr;
  logic        i_br_lt;
  logic        i_br_eq;
  logic        i_mem_ready;
  logic        o_pc_en;
  logic        o_pc_sel;
  logic [3:0]  o_imm_sel;
  logic        o_reg_wen;
  logic        o_br_un;
  logic        o_a_sel;
  logic        o_b_sel;
  logic        o_lui_sel;
  logic [1:0]  o_alu_op;
  logic [3:0]  o_load_type;
  logic        o_load_signed;
  logic        o_mem_rw;
  logic [1:0]  o_wb_sel;
  logic        o_insn_vld;
  logic [31:0] o_instret;
  logic        o_trap;

  modport master (
    input  i_instr, i_br_lt, i_br_eq, i_mem_ready,
    output o_pc_en, o_pc_sel, o_imm_sel, o_reg_wen, o_br_un, o_a_sel, o_b_sel,
           o_lui_sel, o_alu_op, o_load_type, o_load_signed, o_mem_rw, o_wb_sel,
           o_insn_vld, o_instret, o_trap
  );

  modport slave (
    output i_instr, i_br_lt, i_br_eq, i_mem_ready,
    input  o_pc_en, o_pc_sel, o_imm_sel, o_reg_wen, o_br_un, o_a_sel, o_b_sel,
           o_lui_sel, o_alu_op, o_load_type, o_load_signed, o_mem_rw, o_wb_sel,
           o_insn_vld, o_instret, o_trap
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - RV32I multi-cycle sequencer (FETCH/DECODE/EXEC/MEM/WB/TRAP)
// State, retire count and trap are registered; strobes and datapath controls decode from state/class.
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  multicycle_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_t;

  typedef enum logic [3:0] {
    C_NONE, C_R, C_I, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR, C_LUI, C_AUIPC
  } cls_t;

  localparam int CW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(MEM_TIMEOUT - 1);

  state_t        state;
  cls_t          cls;
  cls_t          dec_cls;
  logic [CW-1:0] wait_cnt;
  logic [31:0]   instret;
  logic          trap;
  logic          retire;
  logic          taken;
  logic [2:0]    funct3;

  assign funct3 = bus.i_instr[14:12];

  always_comb begin
    dec_cls = C_NONE;
    case (bus.i_instr[6:0])
      7'b0110011: dec_cls = C_R;
      7'b0010011: dec_cls = C_I;
      7'b0000011: dec_cls = C_LOAD;
      7'b0100011: dec_cls = C_STORE;
      7'b1100011: dec_cls = C_BRANCH;
      7'b1101111: dec_cls = C_JAL;
      7'b1100111: dec_cls = C_JALR;
      7'b0110111: dec_cls = C_LUI;
      7'b0010111: dec_cls = C_AUIPC;
      default:    dec_cls = C_NONE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state    <= S_FETCH;
      cls      <= C_NONE;
      wait_cnt <= '0;
      instret  <= '0;
      trap     <= 1'b0;
    end else begin
      if (retire) begin
        instret <= instret + 32'd1;
      end
      case (state)
        S_FETCH: state <= S_DECODE;
        S_DECODE: begin
          cls <= dec_cls;
          if (dec_cls == C_NONE) begin
            state <= S_TRAP;
            trap  <= 1'b1;
          end else begin
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          wait_cnt <= '0;
          case (cls)
            C_BRANCH:        state <= S_FETCH;
            C_LOAD, C_STORE: state <= S_MEM;
            default:         state <= S_WB;
          endcase
        end
        S_MEM: begin
          if (bus.i_mem_ready) begin
            state <= (cls == C_STORE) ? S_FETCH : S_WB;
          end else if (wait_cnt == WAIT_LAST) begin
            state <= S_TRAP;
            trap  <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_WB:    state <= S_FETCH;
        S_TRAP:  state <= S_TRAP;
        default: state <= S_FETCH;
      endcase
    end
  end

  // Funct3 010/011 are not valid branch conditions; treat them as never taken.
  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'b000:         taken = bus.i_br_eq;
      3'b001:         taken = !bus.i_br_eq;
      3'b100, 3'b110: taken = bus.i_br_lt;
      3'b101, 3'b111: taken = !bus.i_br_lt;
      default:        taken = 1'b0;
    endcase
  end

  always_comb begin
    retire = 1'b0;
    case (state)
      S_EXEC:  retire = (cls == C_BRANCH);
      S_MEM:   retire = (cls == C_STORE) && bus.i_mem_ready;
      S_WB:    retire = 1'b1;
      default: retire = 1'b0;
    endcase
  end

  assign bus.o_pc_en     = retire;
  assign bus.o_insn_vld  = retire;
  assign bus.o_reg_wen   = (state == S_WB);
  assign bus.o_mem_rw    = (state == S_MEM) && (cls == C_STORE);
  assign bus.o_instret   = instret;
  assign bus.o_trap      = trap;

  always_comb begin
    bus.o_pc_sel      = 1'b0;
    bus.o_imm_sel     = 4'b0000;
    bus.o_br_un       = 1'b0;
    bus.o_a_sel       = 1'b0;
    bus.o_b_sel       = 1'b0;
    bus.o_lui_sel     = 1'b0;
    bus.o_alu_op      = 2'b00;
    bus.o_load_type   = 4'b0000;
    bus.o_load_signed = 1'b0;
    bus.o_wb_sel      = 2'b00;
    case (cls)
      C_R: begin
        bus.o_alu_op = 2'b10;
        bus.o_wb_sel = 2'b01;
      end
      C_I: begin
        bus.o_b_sel  = 1'b1;
        bus.o_alu_op = 2'b11;
        bus.o_wb_sel = 2'b01;
      end
      C_LOAD, C_STORE: begin
        bus.o_imm_sel = (cls == C_STORE) ? 4'b0001 : 4'b0000;
        bus.o_b_sel   = 1'b1;
        case (funct3[1:0])
          2'b00:   bus.o_load_type = 4'b0001;
          2'b01:   bus.o_load_type = 4'b0011;
          2'b10:   bus.o_load_type = 4'b1111;
          default: bus.o_load_type = 4'b0000;
        endcase
        bus.o_load_signed = (cls == C_LOAD) && !funct3[2];
      end
      C_BRANCH: begin
        bus.o_imm_sel = 4'b0010;
        bus.o_a_sel   = 1'b1;
        bus.o_b_sel   = 1'b1;
        bus.o_br_un   = funct3[1];
        bus.o_pc_sel  = taken;
      end
      C_JAL: begin
        bus.o_imm_sel = 4'b0100;
        bus.o_a_sel   = 1'b1;
        bus.o_b_sel   = 1'b1;
        bus.o_wb_sel  = 2'b10;
        bus.o_pc_sel  = 1'b1;
      end
      C_JALR: begin
        bus.o_b_sel  = 1'b1;
        bus.o_wb_sel = 2'b10;
        bus.o_pc_sel = 1'b1;
      end
      C_LUI: begin
        bus.o_imm_sel = 4'b1000;
        bus.o_lui_sel = 1'b1;
        bus.o_b_sel   = 1'b1;
        bus.o_wb_sel  = 2'b01;
      end
      C_AUIPC: begin
        bus.o_imm_sel = 4'b1000;
        bus.o_a_sel   = 1'b1;
        bus.o_b_sel   = 1'b1;
        bus.o_wb_sel  = 2'b01;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multi-cycle sequencer for the RV32I datapath. It decodes the current instruction word and steps each instruction through FETCH/DECODE/EXEC/MEM/WB states. It drives every datapath control input, including a PC load enable and a memory-ready handshake. It sits beside the datapath in the core top and supplies the instruction-valid, retire-count and trap status.

Parameters:
MEM_TIMEOUT, 16, max cycles spent in MEM waiting for i_mem_ready before trapping (≥2)

Ports:
i_clk  in  1  clock
i_reset  in  1  synchronous active-high reset
i_instr  in  32  current instruction word from instruction memory
i_br_lt  in  1  branch comparator less-than
i_br_eq  in  1  branch comparator equal
i_mem_ready  in  1  LSU access complete this cycle
o_pc_en  out  1  PC register load enable
o_pc_sel  out  1  0 = PC+4, 1 = ALU result
o_imm_sel  out  4  0000 I, 0001 S, 0010 B, 0100 J, 1000 U
o_reg_wen  out  1  register file write enable
o_br_un  out  1  unsigned compare
o_a_sel  out  1  0 = rs1, 1 = PC
o_b_sel  out  1  0 = rs2, 1 = immediate
o_lui_sel  out  1  force ALU operand A to zero
o_alu_op  out  2  00 add, 01 sub/compare, 10 R-type funct, 11 I-type funct
o_load_type  out  4  0001 byte, 0011 half, 1111 word
o_load_signed  out  1  sign-extend load
o_mem_rw  out  1  1 = store write
o_wb_sel  out  2  0 load, 1 ALU, 2 PC+4
o_insn_vld  out  1  one-cycle retire strobe
o_instret  out  32  retired-instruction count
o_trap  out  1  sticky illegal-opcode or timeout flag

Behaviour:
- Reset: state=FETCH, o_instret=0, o_trap=0. All enables/strobes (o_pc_en, o_reg_wen, o_mem_rw, o_insn_vld) are 0. Reset anywhere, including mid-MEM, aborts the instruction with no writes.
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP. One cycle each, except MEM.
- FETCH -> DECODE unconditionally.
- DECODE: register the opcode class from i_instr[6:0].
  - Legal classes: R 0110011, I-ALU 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111.
  - Any other opcode -> TRAP. Otherwise -> EXEC.
- EXEC next state:
  - BRANCH -> FETCH.
  - LOAD/STORE -> MEM.
  - All others -> WB.
- MEM: o_mem_rw=1 only for STORE.
  - i_mem_ready=1: STORE -> FETCH; LOAD -> WB.
  - A wait counter starts at 0 on MEM entry. If MEM_TIMEOUT cycles elapse without ready -> TRAP with o_mem_rw=0.
- WB: o_reg_wen=1 for one cycle, then -> FETCH.
- TRAP: absorbing until reset. o_trap=1; all enables are 0.
- Retirement cycle (EXEC for BRANCH, MEM+ready for STORE, WB otherwise):
  - o_pc_en=1, o_insn_vld=1, o_instret+=1. o_instret wraps 0xFFFFFFFF->0.
  - PC and register file update on the same edge. PC+4 is therefore still valid for JAL/JALR writeback.
- o_pc_sel=1 at retirement for:
  - JAL and JALR.
  - BRANCH when taken. funct3 000 eq, 001 !eq, 100/110 lt, 101/111 !lt.
  - o_br_un=funct3[1].
- Datapath controls are combinational from registered class plus i_instr. They are held stable from EXEC through retirement.
  - R: b_sel=0, alu_op=10, wb_sel=1.
  - I-ALU: imm I, b_sel=1, alu_op=11, wb_sel=1.
  - LOAD: imm I, b_sel=1, alu_op=00, wb_sel=0.
    - load_type from funct3[1:0]: 00->0001, 01->0011, 10->1111.
    - load_signed=!funct3[2].
  - STORE: imm S, b_sel=1, alu_op=00. load_type from funct3 as for LOAD (store width).
  - BRANCH: imm B, a_sel=1, b_sel=1, alu_op=00 (target).
  - JAL: imm J, a_sel=1, b_sel=1, wb_sel=2.
  - JALR: imm I, a_sel=0, b_sel=1, wb_sel=2.
  - LUI: imm U, lui_sel=1, b_sel=1, wb_sel=1.
  - AUIPC: imm U, a_sel=1, b_sel=1, wb_sel=1.
- In FETCH/DECODE: o_pc_en=o_reg_wen=o_mem_rw=0.

Test Plan:
- Reset, then i_instr=0x00500093 (addi x1,x0,5) -> FETCH,DECODE,EXEC,WB. reg_wen=1, pc_en=1, insn_vld=1 in cycle 4. pc_sel=0, wb_sel=1. o_instret=1.
- BEQ 0x00208463 with i_br_eq=1 -> retire in EXEC (cycle 3), pc_sel=1, reg_wen=0. With i_br_eq=0 -> pc_sel=0.
- LW 0x0000A103, i_mem_ready low 3 MEM cycles then high -> MEM lasts 4 cycles. Then WB with load_type=1111, load_signed=1, wb_sel=0. Total 7 cycles.
- SW 0x0020A023 with ready on first MEM cycle -> mem_rw=1 exactly 1 cycle, retire in MEM, reg_wen never 1.
- i_instr=0x00000000 -> TRAP after DECODE. o_trap=1, no pc_en/insn_vld thereafter until i_reset.
- LOAD with ready never asserted -> TRAP after 16 MEM cycles. Assert i_reset mid-MEM in a second run -> FETCH next cycle, o_instret=0, o_trap=0.
